// File: rtl/f_ifq_pkg.sv
// Shared definitions for the instruction fetch queue and the fetch stage.
package f_ifq_pkg;

    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_3000;
    localparam int          ENTRY_W      = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/f_ifq_if.sv
// Fetch/decode handshake bundle around the instruction fetch queue.
interface f_ifq_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_ready;
    logic          flush;
    logic          flush_keep;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush, flush_keep,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush, flush_keep,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/f_ifq_mem.sv
// Entry storage: synchronous write at the tail, combinational read at the head.
module f_ifq_mem
    import f_ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [PW-1:0]      waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [PW-1:0]      raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/f_ifq.sv
// Instruction fetch queue: circular buffer of {PC, instr} with valid/ready
// on both sides and a redirect flush that can keep one delay-slot entry.
module f_ifq
    import f_ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic  clk,
    input  logic  reset,
    f_ifq_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_pop;
    logic [CW-1:0] count_q, count_d, remain;
    logic          in_ready, out_valid, push, pop, we;
    ifq_entry_t    wdata, rdata;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;
    assign wdata     = '{pc: bus.in_pc, instr: bus.in_instr};

    f_ifq_mem #(.DEPTH(DEPTH), .PW(PW)) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (tail_q),
        .wdata_i (wdata),
        .raddr_i (head_q),
        .rdata_o (rdata)
    );

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        we       = 1'b0;
        head_pop = pop ? head_q + PW'(1) : head_q;
        remain   = count_q - CW'(pop);
        if (!bus.flush) begin
            we      = push;
            head_d  = head_pop;
            tail_d  = push ? tail_q + PW'(1) : tail_q;
            count_d = count_q + CW'(push) - CW'(pop);
        end else begin
            head_d = head_pop;
            if (!bus.flush_keep) begin
                tail_d  = head_pop;
                count_d = '0;
            end else if (remain != '0) begin
                tail_d  = head_pop + PW'(1);
                count_d = CW'(1);
            end else if (push) begin
                // Queue drained by this pop, so tail_q already equals head_pop.
                we      = 1'b1;
                tail_d  = tail_q + PW'(1);
                count_d = CW'(1);
            end else begin
                tail_d  = head_pop;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_valid ? rdata.pc : RESET_PC;
    assign bus.out_instr = out_valid ? rdata.instr : 32'h0;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_f_ifq.sv
// Self-checking bench for f_ifq: queue-based reference model plus directed cases.
module tb_f_ifq;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] mq [$];

    f_ifq_if #(.DEPTH(DEPTH)) ifc ();

    f_ifq #(.DEPTH(DEPTH), .RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: apply the queue rules to the model at the clock edge.
    task automatic model_step();
        int          n;
        bit          ps, pp;
        logic [63:0] e;
        n  = mq.size();
        ps = ifc.in_valid && (n < DEPTH);
        pp = ifc.out_ready && (n > 0);
        if (reset) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (!ifc.flush) begin
                if (ps) mq.push_back({ifc.in_pc, ifc.in_instr});
            end else if (!ifc.flush_keep) begin
                mq.delete();
            end else if (mq.size() >= 1) begin
                e = mq[0];
                mq.delete();
                mq.push_back(e);
            end else if (ps) begin
                mq.push_back({ifc.in_pc, ifc.in_instr});
            end
        end
    endtask

    task automatic compare_model();
        int          n;
        logic [63:0] h;
        n = mq.size();
        h = (n != 0) ? mq[0] : {32'h0000_3000, 32'h0};
        chk("m_out_valid", {31'b0, ifc.out_valid}, {31'b0, n != 0});
        chk("m_in_ready",  {31'b0, ifc.in_ready},  {31'b0, n != DEPTH});
        chk("m_count",     32'(ifc.count),         32'(n));
        chk("m_out_pc",    ifc.out_pc,             h[63:32]);
        chk("m_out_instr", ifc.out_instr,          h[31:0]);
    endtask

    task automatic cycle(input logic rst, input logic iv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic ordy,
                         input logic fl, input logic fk);
        reset          = rst;
        ifc.in_valid   = iv;
        ifc.in_pc      = pc;
        ifc.in_instr   = ins;
        ifc.out_ready  = ordy;
        ifc.flush      = fl;
        ifc.flush_keep = fk;
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'h2401_0001 + (pc - 32'h0000_3000);
    endfunction

    task automatic push(input logic [31:0] pc);
        cycle(0, 1, pc, ins_of(pc), 0, 0, 0);
    endtask

    task automatic idle();
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        do_reset();
        idle();
        // 1. reset state, then a single push
        chk("t1_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        chk("t1_out_pc",    ifc.out_pc,    32'h0000_3000);
        chk("t1_out_instr", ifc.out_instr, 32'h0);
        chk("t1_in_ready",  {31'b0, ifc.in_ready}, 32'd1);
        chk("t1_count",     32'(ifc.count), 32'd0);
        push(32'h3000);
        chk("t1_push_valid", {31'b0, ifc.out_valid}, 32'd1);
        chk("t1_push_pc",    ifc.out_pc,    32'h3000);
        chk("t1_push_instr", ifc.out_instr, 32'h2401_0001);
        chk("t1_push_count", 32'(ifc.count), 32'd1);

        // 2. fill, refused push, ordered drain
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h3000 + 32'(4 * i));
        chk("t2_full_count", 32'(ifc.count), 32'd4);
        chk("t2_full_ready", {31'b0, ifc.in_ready}, 32'd0);
        push(32'h3010);
        chk("t2_refused_count", 32'(ifc.count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_pop_pc", ifc.out_pc, 32'h3000 + 32'(4 * i));
            cycle(0, 0, 32'h0, 32'h0, 1, 0, 0);
        end
        chk("t2_drained_valid", {31'b0, ifc.out_valid}, 32'd0);

        // 3. streaming with pointer wrap
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 32'h3000 + 32'(4 * i), ins_of(32'h3000 + 32'(4 * i)), 1, 0, 0);
            chk("t3_count", 32'(ifc.count), 32'd1);
            chk("t3_pc",    ifc.out_pc, 32'h3000 + 32'(4 * i));
        end

        // 4. flush without keep
        do_reset();
        push(32'h3008); push(32'h300C); push(32'h3010);
        cycle(0, 1, 32'h3014, ins_of(32'h3014), 0, 1, 0);
        chk("t4_count", 32'(ifc.count), 32'd0);
        chk("t4_valid", {31'b0, ifc.out_valid}, 32'd0);
        chk("t4_pc",    ifc.out_pc, 32'h3000);

        // 5. flush with keep and a pop
        do_reset();
        push(32'h3008); push(32'h300C); push(32'h3010);
        cycle(0, 1, 32'h3014, ins_of(32'h3014), 1, 1, 1);
        chk("t5_count", 32'(ifc.count), 32'd1);
        chk("t5_pc",    ifc.out_pc, 32'h300C);
        cycle(0, 0, 32'h0, 32'h0, 1, 0, 0);
        chk("t5_no_3014", 32'(ifc.count), 32'd0);

        // 6. flush with keep after draining pop keeps the push; reset mid-stream
        do_reset();
        push(32'h3020);
        cycle(0, 1, 32'h3024, ins_of(32'h3024), 1, 1, 1);
        chk("t6_count", 32'(ifc.count), 32'd1);
        chk("t6_pc",    ifc.out_pc, 32'h3024);
        push(32'h3028);
        cycle(1, 1, 32'h302C, ins_of(32'h302C), 0, 1, 1);
        chk("t6_rst_valid", {31'b0, ifc.out_valid}, 32'd0);
        chk("t6_rst_pc",    ifc.out_pc, 32'h3000);
        chk("t6_rst_instr", ifc.out_instr, 32'h0);
        chk("t6_rst_ready", {31'b0, ifc.in_ready}, 32'd1);
        chk("t6_rst_count", 32'(ifc.count), 32'd0);

        // Randomized traffic in phases biased toward filling and draining
        for (int i = 0; i < 3000; i++) begin
            int ph;
            ph = (i / 200) % 3;
            cycle($urandom_range(99) < 1,
                  $urandom_range(99) < (ph == 0 ? 90 : ph == 1 ? 30 : 60),
                  $urandom, $urandom,
                  $urandom_range(99) < (ph == 0 ? 20 : ph == 1 ? 90 : 50),
                  $urandom_range(99) < 8,
                  $urandom_range(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
